// File: rtl/mips_alu_pkg.sv
// Shared definitions for the multi-cycle MIPS ALU: op codes and FSM states.
package mips_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  typedef enum logic {IDLE, BUSY} alu_state_t;

  // True for the ops that run on the iterative mul/div datapath.
  function automatic logic is_multicycle(logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// One iteration per cycle while en=1; last flags the final iteration, and
// hi_out/lo_out then carry the finished HI/LO values.
module mips_muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] acc_q, acc_d;  // product upper half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;    // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_sh;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  // One iteration step; its result is the state after this cycle.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    // Remainder stays below the divisor, so a clear top bit means no borrow.
    div_ge   = ~div_diff[WIDTH];
    if (div_q) begin
      hi_out = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      lo_out = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_out = mul_sum[WIDTH:1];
      lo_out = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign last = en && (cnt_q == '0);

  // Next-state: capture operands on load, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    acc_d = acc_q;
    lo_d  = lo_q;
    b_d   = b_q;
    if (load) begin
      cnt_d = CNT_W'(WIDTH - 1);
      div_d = is_div;
      acc_d = '0;
      lo_d  = a;
      b_d   = b;
    end else if (en) begin
      acc_d = hi_out;
      lo_d  = lo_out;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= 1'b0;
      acc_q <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      acc_q <= acc_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS ALU: registered single-cycle ops plus iterative MULTU/DIVU
// into HI/LO. Optional signed-overflow output enabled by MIPS_ALU_OVF_EN.
module mips_alu_mc
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MIPS_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             md_load;
  logic             md_last;
  logic [WIDTH-1:0] md_hi, md_lo;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             raw_ovf;
  logic [WIDTH-1:0] alu_res;

`ifdef MIPS_ALU_OVF_EN
  logic ovf_q, ovf_d;
  logic alu_ovf;
`endif

  mips_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .en     (state_q == BUSY),
    .is_div (op == OP_DIVU),
    .a      (a),
    .b      (b),
    .last   (md_last),
    .hi_out (md_hi),
    .lo_out (md_lo)
  );

  // Single-cycle ALU; op[2] selects subtract (invert B, carry-in 1).
  always_comb begin
    b_eff   = op[2] ? ~b : b;
    sum     = a + b_eff + WIDTH'(op[2]);
    raw_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = sum;
      // Sign of the true difference: flip the wrapped sign on overflow.
      OP_SLT:  alu_res = WIDTH'(sum[WIDTH-1] ^ raw_ovf);
      OP_NOR:  alu_res = ~(a | b);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

`ifdef MIPS_ALU_OVF_EN
  // Overflow is reported only for ADD and SUB.
  assign alu_ovf = ((op == OP_ADD) || (op == OP_SUB)) && raw_ovf;
`endif

  // FSM next-state and output-register updates.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    md_load  = 1'b0;
`ifdef MIPS_ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (is_multicycle(op)) begin
            md_load = 1'b1;
            state_d = BUSY;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
`ifdef MIPS_ALU_OVF_EN
            ovf_d    = alu_ovf;
`endif
          end
        end
      end
      BUSY: begin
        if (md_last) begin
          hi_d    = md_hi;
          lo_d    = md_lo;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MIPS_ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MIPS_ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
`ifdef MIPS_ALU_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_mips_alu_mc.sv
// Scoreboard bench for mips_alu_mc (WIDTH=8): driver pushes model results,
// monitor pops and compares on every done pulse.
module tb_mips_alu_mc;

  localparam int W = 8;
  localparam longint unsigned MASK = (longint'(1) << W) - 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    bit           chk_ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, zero;
  logic [W-1:0] result, hi, lo;
`ifdef MIPS_ALU_OVF_EN
  logic         ovf;
`endif

  mips_alu_mc #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result),
    .zero   (zero),
    .hi     (hi),
    .lo     (lo)
`ifdef MIPS_ALU_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  exp_t sb[$];

  // Reference model state.
  longint unsigned m_res = 0, m_hi = 0, m_lo = 0;
  bit m_ovf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sgn(input logic [W-1:0] x);
    longint s = longint'(x);
    if (x[W-1]) s = s - (longint'(1) << W);
    return s;
  endfunction

  task automatic model_issue(input logic [3:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y, input int c);
    exp_t e;
    longint unsigned xa = longint'(x), ya = longint'(y), p;
    longint s;
    longint smax = (longint'(1) << (W - 1)) - 1;
    longint smin = -(longint'(1) << (W - 1));
    bit single = 1;
    bit v = 0;
    case (o)
      4'b0000: m_res = xa & ya;
      4'b0001: m_res = xa | ya;
      4'b0010: begin
        m_res = (xa + ya) & MASK;
        s = sgn(x) + sgn(y);
        v = (s > smax) || (s < smin);
      end
      4'b0110: begin
        m_res = (xa - ya) & MASK;
        s = sgn(x) - sgn(y);
        v = (s > smax) || (s < smin);
      end
      4'b0111: m_res = (sgn(x) < sgn(y)) ? 1 : 0;
      4'b1100: m_res = ~(xa | ya) & MASK;
      4'b1010: m_res = m_hi;
      4'b1011: m_res = m_lo;
      4'b1000: begin
        p = xa * ya;
        m_hi = (p >> W) & MASK;
        m_lo = p & MASK;
        single = 0;
      end
      4'b1001: begin
        if (ya == 0) begin
          m_lo = MASK;
          m_hi = xa;
        end else begin
          m_lo = xa / ya;
          m_hi = xa % ya;
        end
        single = 0;
      end
      default: m_res = 0;
    endcase
    if (single) m_ovf = v;
    e.cyc = single ? c + 1 : c + W + 1;
    e.res = m_res[W-1:0];
    e.z = (m_res == 0);
    e.hi = m_hi[W-1:0];
    e.lo = m_lo[W-1:0];
    e.ovf = m_ovf;
    e.chk_ovf = single;
    sb.push_back(e);
  endtask

  // Wait for ready, present one request for a single cycle.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_wait", {63'd0, ready}, 64'd1);
      return;
    end
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    model_issue(o, x, y, cyc);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {63'd0, done}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("result", 64'(result), 64'(e.res));
          chk("zero", {63'd0, zero}, {63'd0, e.z});
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("ready_at_done", {63'd0, ready}, 64'd1);
`ifdef MIPS_ALU_OVF_EN
          if (e.chk_ovf) chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
`endif
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ro;
    logic [W-1:0] ra, rb;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    issue(4'b0110, 8'h05, 8'h05);
    issue(4'b0111, 8'hFD, 8'h02);
    issue(4'b0111, 8'h7F, 8'h80);

    // MULTU with ready checks and ignored starts while busy.
    issue(4'b1000, 8'hFF, 8'hFF);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk("busy_ready", {63'd0, ready}, 64'd0);
      start = 1'b1;
      op = 4'b0010;
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      #1 start = 1'b0;
    end
    issue(4'b1010, 8'h00, 8'h00);
    issue(4'b1011, 8'h00, 8'h00);
    issue(4'b1001, 8'd100, 8'd7);
    issue(4'b1001, 8'h35, 8'h00);
    issue(4'b1010, 8'h00, 8'h00);
    issue(4'b0010, 8'h7F, 8'h01);
    issue(4'b0110, 8'h80, 8'h01);
    issue(4'b0010, 8'h01, 8'h01);
    issue(4'b1100, 8'hF0, 8'h0F);
    issue(4'b1111, 8'hAA, 8'h55);
    drain();

    // Reset in cycle 4 of a MULTU aborts it without a done pulse.
    issue(4'b1000, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    m_res = 0;
    m_hi = 0;
    m_lo = 0;
    m_ovf = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", {63'd0, ready}, 64'd1);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_zero", {63'd0, zero}, 64'd1);
    chk("abort_result", 64'(result), 64'd0);
    for (int k = 0; k < W + 2; k++) begin
      chk("abort_nodone", {63'd0, done}, 64'd0);
      @(negedge clk);
    end

    // Randomised traffic, mixing back-to-back and gapped requests.
    for (int i = 0; i < 300; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = 8'($urandom_range(0, 3));
        2: ra = 8'($urandom_range(0, 3));
        default: ;
      endcase
      issue(ro, ra, rb);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
